// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Brief    : Operand/result valid-ready bundle for seq_divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Radix-2 restoring unsigned divider, one quotient bit per clock.
//            Macro SEQ_DIVIDER_DIV0_X_EN makes divide-by-zero results all-X.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    seq_divider_if.slave bus
);
    localparam int                 C_CNT_W    = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [C_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_rem_q,   w_rem_d;
    logic [WIDTH-1:0]   r_quo_q,   w_quo_d;
    logic [WIDTH-1:0]   r_div_q,   w_div_d;
    logic               r_dz_q,    w_dz_d;

    // Shifted remainder needs WIDTH+1 bits; the trial's top bit is its sign.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;

    assign w_rem_sh = {r_rem_q, r_quo_q[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div_q};
    assign w_fits   = ~w_trial[WIDTH];

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_rem_d   = r_rem_q;
        w_quo_d   = r_quo_q;
        w_div_d   = r_div_q;
        w_dz_d    = r_dz_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_quo_d   = bus.dividend;
                    w_div_d   = bus.divisor;
                    w_rem_d   = '0;
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_div_q == '0) begin
                    w_dz_d    = 1'b1;
`ifdef SEQ_DIVIDER_DIV0_X_EN
                    w_quo_d   = {WIDTH{1'bx}};
                    w_rem_d   = {WIDTH{1'bx}};
`else
                    w_quo_d   = '1;
                    w_rem_d   = r_quo_q;
`endif
                    w_state_d = S_DONE;
                end else begin
                    w_dz_d    = 1'b0;
                    w_rem_d   = '0;
                    w_cnt_d   = C_CNT_LAST;
                    w_state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Ternaries keep X operands propagating into the results.
                w_rem_d = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                w_quo_d = {r_quo_q[WIDTH-2:0], w_fits};
                if (r_cnt_q == '0) begin
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - C_CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_rem_q   <= '0;
            r_quo_q   <= '0;
            r_div_q   <= '0;
            r_dz_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_rem_q   <= w_rem_d;
            r_quo_q   <= w_quo_d;
            r_div_q   <= w_div_d;
            r_dz_q    <= w_dz_d;
        end
    end

    assign bus.in_ready    = (r_state_q == S_IDLE);
    assign bus.out_valid   = (r_state_q == S_DONE);
    assign bus.quotient    = r_quo_q;
    assign bus.remainder   = r_rem_q;
    assign bus.div_by_zero = r_dz_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Directed and random checks of seq_divider at WIDTH=32 and 66.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_divider_if #(.WIDTH(32)) b32 ();
    seq_divider_if #(.WIDTH(66)) b66 ();

    seq_divider #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .bus(b32.slave));
    seq_divider #(.WIDTH(66)) u_div66 (.clk(clk), .rst(rst), .bus(b66.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One operation on both widths in lockstep, out_ready held high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input string tag);
        logic [65:0] eq66, er66, q66, r66;
        logic [31:0] q32, r32;
        logic        dz32, dz66, dz_exp;
        int          lat32, lat66;
        dz_exp = (b == 32'd0);
        eq66   = dz_exp ? {66{1'b1}} : {34'd0, eq};
        er66   = {34'd0, er};
`ifdef SEQ_DIVIDER_DIV0_X_EN
        if (dz_exp) begin
            eq = 'x; er = 'x; eq66 = 'x; er66 = 'x;
        end
`endif
        q32 = '0; r32 = '0; q66 = '0; r66 = '0; dz32 = 1'b0; dz66 = 1'b0;
        @(negedge clk);
        check({tag, " rdy32"}, 128'(b32.in_ready), 128'd1);
        check({tag, " rdy66"}, 128'(b66.in_ready), 128'd1);
        b32.dividend = a;          b32.divisor = b;          b32.in_valid = 1'b1; b32.out_ready = 1'b1;
        b66.dividend = {34'd0, a}; b66.divisor = {34'd0, b}; b66.in_valid = 1'b1; b66.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        b66.in_valid = 1'b0;
        lat32 = 0;
        lat66 = 0;
        for (int n = 1; n <= 80 && (lat32 == 0 || lat66 == 0); n++) begin
            @(posedge clk);
            #1;
            if (lat32 == 0 && b32.out_valid) begin
                lat32 = n; q32 = b32.quotient; r32 = b32.remainder; dz32 = b32.div_by_zero;
            end
            if (lat66 == 0 && b66.out_valid) begin
                lat66 = n; q66 = b66.quotient; r66 = b66.remainder; dz66 = b66.div_by_zero;
            end
        end
        @(posedge clk);
        check({tag, " lat32"}, 128'(lat32), dz_exp ? 128'd1 : 128'd33);
        check({tag, " lat66"}, 128'(lat66), dz_exp ? 128'd1 : 128'd67);
        check({tag, " q32"},   128'(q32),   128'(eq));
        check({tag, " r32"},   128'(r32),   128'(er));
        check({tag, " dz32"},  128'(dz32),  128'(dz_exp));
        check({tag, " q66"},   128'(q66),   128'(eq66));
        check({tag, " r66"},   128'(r66),   128'(er66));
        check({tag, " dz66"},  128'(dz66),  128'(dz_exp));
    endtask

    initial begin
        logic [31:0] ra, rb;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        b32.in_valid = 1'b0; b32.dividend = '0; b32.divisor = '0; b32.out_ready = 1'b0;
        b66.in_valid = 1'b0; b66.dividend = '0; b66.divisor = '0; b66.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst rdy32",  128'(b32.in_ready),    128'd1);
        check("rst ov32",   128'(b32.out_valid),   128'd0);
        check("rst q32",    128'(b32.quotient),    128'd0);
        check("rst r32",    128'(b32.remainder),   128'd0);
        check("rst dz32",   128'(b32.div_by_zero), 128'd0);
        check("rst rdy66",  128'(b66.in_ready),    128'd1);
        check("rst ov66",   128'(b66.out_valid),   128'd0);
        check("rst q66",    128'(b66.quotient),    128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h1,        32'h1,        32'h1,        32'h0,       "one_by_one");
        run_op(32'h2537f12,  32'h7322a,    32'h52,       32'h56d9e,   "mixed");
        run_op(32'h2537f12,  32'h0,        32'hffffffff, 32'h2537f12, "div0");
        run_op(32'd5,        32'd9,        32'd0,        32'd5,       "a_lt_b");
        run_op(32'hdeadbeef, 32'h1,        32'hdeadbeef, 32'h0,       "by_one");
        run_op(32'hffffffff, 32'hffffffff, 32'h1,        32'h0,       "ones");
        run_op(32'hffffffff, 32'h2,        32'h7fffffff, 32'h1,       "half");

        // Backpressure on the 32-bit unit; junk in_valid while busy/done.
        @(negedge clk);
        b32.dividend = 32'd1000; b32.divisor = 32'd7; b32.in_valid = 1'b1; b32.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b32.dividend = 32'd5; b32.divisor = 32'd1;
        for (int n = 0; n < 40 && !b32.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("bp ready_busy", 128'(b32.in_ready), 128'd0);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            check("bp ov",  128'(b32.out_valid), 128'd1);
            check("bp rdy", 128'(b32.in_ready),  128'd0);
            check("bp q",   128'(b32.quotient),  128'd142);
            check("bp r",   128'(b32.remainder), 128'd6);
        end
        @(negedge clk);
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp ov_drop",  128'(b32.out_valid), 128'd0);
        check("bp rdy_back", 128'(b32.in_ready),  128'd1);

        // Reset partway through an operation.
        @(negedge clk);
        b32.dividend = 32'hffff0000; b32.divisor = 32'd3; b32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst rdy", 128'(b32.in_ready),  128'd1);
        check("mid_rst ov",  128'(b32.out_valid), 128'd0);
        check("mid_rst q",   128'(b32.quotient),  128'd0);
        check("mid_rst r",   128'(b32.remainder), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd100, 32'd7, 32'd14, 32'd2, "after_rst");

        for (int i = 0; i < 100; i++) begin
            ra = $random;
            rb = $random;
            if (i % 4 == 0) rb = rb >> (i % 29);
            if (rb == 32'd0) run_op(ra, rb, 32'hffffffff, ra, "rand");
            else             run_op(ra, rb, ra / rb, ra % rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
